// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - sequential instruction fetch from a synchronous ROM with stall, redirect and drain
module inst_fetch #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int LAST_ADDR = 63
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              id_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [15:0]       inst_cnt,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] resp_pc, resp_pc_nxt;
    logic              resp_valid, resp_valid_nxt;
    logic              active;
    logic              stall;
    logic              accept;

    // Address mux and decode-side outputs; a stall re-reads resp_pc so the ROM output stays put
    always_comb begin
        active   = (state == RUN) || (state == DRAIN);
        stall    = resp_valid && !id_ready;
        if_valid = resp_valid && active;
        if_inst  = rom_data;
        if_pc    = resp_pc;
        done     = (state == DONE);
        accept   = if_valid && id_ready && !branch_valid;
        if (branch_valid && active)
            rom_addr = branch_target;
        else if (stall || state == DRAIN)
            rom_addr = resp_pc;
        else
            rom_addr = pc;
    end

    // Next-state logic; issuing LAST_ADDR by any path (sequential or redirect) enters DRAIN
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        resp_pc_nxt    = resp_pc;
        resp_valid_nxt = resp_valid;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            RUN, DRAIN: begin
                if (branch_valid) begin
                    resp_pc_nxt    = branch_target;
                    resp_valid_nxt = 1'b1;
                    pc_nxt         = branch_target + ONE;
                    state_nxt      = (branch_target == LAST) ? DRAIN : RUN;
                end else if (stall) begin
                    state_nxt = state;
                end else if (state == RUN) begin
                    resp_pc_nxt    = pc;
                    resp_valid_nxt = 1'b1;
                    pc_nxt         = pc + ONE;
                    if (pc == LAST)
                        state_nxt = DRAIN;
                end else begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = DONE;
                end
            end
            DONE: state_nxt = DONE;
            default: begin
                state_nxt      = IDLE;
                resp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and fetch registers
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            resp_pc    <= resp_pc_nxt;
            resp_valid <= resp_valid_nxt;
        end
    end

    // Saturating count of instructions accepted by decode (killed ones excluded)
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n)
            inst_cnt <= '0;
        else if (accept && inst_cnt != 16'hFFFF)
            inst_cnt <= inst_cnt + 16'd1;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch against a program-order fetch model
module tb_inst_fetch;

    localparam int LAST = 12;

    typedef struct packed {
        logic [5:0]  pc;
        logic [31:0] inst;
    } exp_t;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        id_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic [5:0]  branch_target = 6'd0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [5:0]  if_pc;
    logic [15:0] inst_cnt;
    logic        done;

    logic [31:0] rom [64];
    exp_t        q [$];
    exp_t        mon_e;
    int          vectors = 0;
    int          errors = 0;

    // model: 0 idle, 1 first issue cycle, 2 presenting m_pc, 3 finished
    int          m_st = 0;
    int          m_pc = 0;
    int          m_cnt = 0;

    inst_fetch #(.ADDR_W(6), .DATA_W(32), .LAST_ADDR(LAST)) dut (
        .clka(clka), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .id_ready(id_ready), .branch_valid(branch_valid), .branch_target(branch_target),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .inst_cnt(inst_cnt), .done(done)
    );

    always #5 clka = ~clka;

    always @(posedge clka) rom_data <= rom[rom_addr];

    // Monitor: every presented instruction must match the next scoreboard entry
    always @(negedge clka) begin
        if (if_valid) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got pc=%0d inst=%h, required no valid", if_pc, if_inst);
            end else begin
                mon_e = q.pop_front();
                if (if_pc !== mon_e.pc || if_inst !== mon_e.inst) begin
                    errors++;
                    $display("FAIL present: got pc=%0d inst=%h, required pc=%0d inst=%h",
                             if_pc, if_inst, mon_e.pc, mon_e.inst);
                end
            end
        end else if (q.size() != 0) begin
            vectors++;
            errors++;
            mon_e = q.pop_front();
            $display("FAIL missing_valid: got if_valid=0, required pc=%0d inst=%h", mon_e.pc, mon_e.inst);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; the model decides what decode should see this cycle
    task automatic step(input logic r, input logic rdy, input logic br, input logic [5:0] tgt);
        run = r;
        id_ready = rdy;
        branch_valid = br;
        branch_target = tgt;
        case (m_st)
            0: if (r) m_st = 1;
            1: begin
                m_pc = br ? int'(tgt) : 0;
                m_st = 2;
            end
            2: begin
                q.push_back({6'(m_pc), rom[m_pc]});
                if (br) begin
                    m_pc = int'(tgt);
                end else if (rdy) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_pc == LAST) m_st = 3;
                    else m_pc = (m_pc + 1) % 64;
                end
            end
            default: ;
        endcase
        @(posedge clka);
        #1;
        chk("done", 32'(done), 32'(m_st == 3));
        chk("inst_cnt", 32'(inst_cnt), 32'(m_cnt));
    endtask

    // Mid-cycle asynchronous reset; called just after a rising edge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_inst_cnt", 32'(inst_cnt), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        m_st = 0;
        m_pc = 0;
        m_cnt = 0;
        run = 1'b0;
        branch_valid = 1'b0;
        @(posedge clka);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && m_st != 3; i++) step(0, 1, 0, 6'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h00000827;
        rom[1] = 32'h0001102B;
        rom[2] = 32'h00421820;

        repeat (3) @(posedge clka);
        #1;
        rst_n = 1'b1;
        chk("init_if_valid", 32'(if_valid), 32'd0);
        chk("init_rom_addr", 32'(rom_addr), 32'd0);
        chk("init_if_pc", 32'(if_pc), 32'd0);
        chk("init_inst_cnt", 32'(inst_cnt), 32'd0);
        chk("init_done", 32'(done), 32'd0);

        // idle ignores branches; run starts at 0
        step(0, 1, 1, 6'd7);
        step(1, 1, 1, 6'd9);
        step(0, 1, 0, 6'd0);
        step(0, 1, 0, 6'd0);
        repeat (3) step(0, 0, 0, 6'd0);
        step(0, 1, 0, 6'd0);
        step(0, 1, 0, 6'd0);
        step(0, 0, 1, 6'd10);
        run_to_done(40);
        repeat (4) step(1, 1, 1, 6'd3);

        // reset while presenting pc 2, then restart
        async_reset();
        step(1, 1, 0, 6'd0);
        repeat (3) step(0, 1, 0, 6'd0);
        async_reset();
        step(1, 1, 0, 6'd0);
        repeat (2) step(0, 1, 0, 6'd0);

        // redirect beyond LAST wraps through 63 -> 0
        step(0, 1, 1, 6'd62);
        run_to_done(80);
        step(0, 1, 0, 6'd0);

        // redirect straight to LAST drains, also from the first issue cycle
        async_reset();
        step(1, 1, 0, 6'd0);
        step(0, 1, 0, 6'd0);
        step(0, 1, 0, 6'd0);
        step(0, 0, 1, 6'(LAST));
        step(0, 0, 0, 6'd0);
        run_to_done(5);
        async_reset();
        step(1, 1, 0, 6'd0);
        step(0, 1, 1, 6'(LAST));
        run_to_done(5);

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            async_reset();
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom));
            for (int c = 0; c < 160 && m_st != 3; c++)
                step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 9) == 0), 6'($urandom));
            repeat (3) step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 6'($urandom));
        end

        step(0, 1, 0, 6'd0);
        @(negedge clka);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, instruction ROM address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter LAST_ADDR, default 63, last sequential address fetched before draining.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clka  in  1  clock, rising edge; rst_n  in  1  reset, async assert, active low.
REQ-005 SHALL have: run  in  1  start pulse, sampled in IDLE only.
REQ-006 SHALL have: rom_addr  out  ADDR_W  address to synchronous ROM (data returned one clka edge later).
REQ-007 SHALL have: rom_data  in  DATA_W  ROM read data for address presented in previous cycle.
REQ-008 SHALL have: id_ready  in  1  decode stage accepts if_inst this cycle.
REQ-009 SHALL have: branch_valid  in  1  redirect request from decode; branch_target  in  ADDR_W  redirect address.
REQ-010 SHALL have: if_valid  out  1; if_inst  out  DATA_W; if_pc  out  ADDR_W  instruction and its address to decode.
REQ-011 SHALL have: inst_cnt  out  16  accepted-instruction count; done  out  1  fetch finished.

Function
REQ-012 SHALL hold registers state{IDLE,RUN,DRAIN,DONE}, pc (next address to issue), resp_valid, resp_pc (address whose data is on rom_data), inst_cnt.
REQ-013 SHALL define stall = resp_valid & ~id_ready; rom_addr = branch_valid&(RUN|DRAIN) ? branch_target : (stall|DRAIN) ? resp_pc : pc (combinational).
REQ-014 SHALL drive if_valid = resp_valid & (RUN|DRAIN), if_inst = rom_data, if_pc = resp_pc; stall re-reads same address so if_inst stays stable while held.
REQ-015 IDLE: no fetch, if_valid 0; run=1 -> RUN next edge with pc=0; branch_valid ignored.
REQ-016 RUN, branch_valid=1: resp_pc<=branch_target, resp_valid<=1, pc<=branch_target+1 mod 2^ADDR_W; instruction presented this cycle is killed (not counted).
REQ-017 RUN, no branch, stall: all registers hold.
REQ-018 RUN, no branch, no stall: resp_pc<=pc, resp_valid<=1, pc<=pc+1 mod 2^ADDR_W; if pc==LAST_ADDR -> DRAIN.
REQ-019 DRAIN: no new address issued; branch_valid -> redirect as REQ-016 and return to RUN; else stall -> hold; else resp_valid<=0, -> DONE.
REQ-020 DONE: if_valid 0, done 1, branch_valid and run ignored, stays until reset.
REQ-021 Branch has priority over stall in the same cycle; branch to address > LAST_ADDR permitted, sequential fetch wraps 2^ADDR_W-1 -> 0 and DRAIN triggers only on issuing LAST_ADDR.
REQ-022 inst_cnt SHALL increment by 1 on if_valid & id_ready & ~branch_valid, saturating at 0xFFFF.
REQ-023 Throughput SHALL be one instruction per cycle with id_ready=1; first if_valid 2 cycles after run sampled; redirect adds zero bubbles (target valid next cycle).

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, pc=0, resp_valid=0, resp_pc=0, inst_cnt=0; outputs if_valid=0, done=0, rom_addr=0, if_pc=0.
REQ-025 Reset asserted mid-RUN/DRAIN SHALL abort fetch with no further if_valid until a new run after release.

Verification
REQ-026 ROM preloaded 0x00000827@0, 0x0001102B@1, 0x00421820@2; run pulse, id_ready=1 -> if_valid from cycle 2, (if_pc,if_inst)=(0,0x00000827),(1,0x0001102B),(2,0x00421820) on consecutive cycles.
REQ-027 id_ready=0 for 3 cycles while if_pc=1 -> if_inst holds 0x0001102B, inst_cnt unchanged, pc=1 presented next after release without skip or duplicate.
REQ-028 branch_valid=1, branch_target=10 while if_pc=3 and id_ready=0 -> pc 3 not counted, next cycle if_pc=10, then 11.
REQ-029 LAST_ADDR=4, id_ready=1 -> if_pc 0..4, then if_valid=0, done=1, inst_cnt=5; later run and branch_valid have no effect.
REQ-030 rst_n pulsed low asynchronously (mid-cycle) at if_pc=2 -> if_valid, inst_cnt, rom_addr to 0 immediately; after release, run restarts at if_pc=0.
REQ-031 branch_target=63 with LAST_ADDR=63 -> if_pc 63 then DRAIN, done=1 after acceptance; branch_target=62 with LAST_ADDR=5 -> if_pc 62,63,0,1..5 then done.
